// File: rtl/multicycle_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multicycle_ctrl : multi-cycle MIPS control sequencer (IF/ID/EX/MEM/WB)   |
// |                   with req/ready memory handshakes and fetch timeout.    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module multicycle_ctrl #(
  parameter int IM_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic [1:0]  Jump,
  output logic [1:0]  Branch_sel,
  output logic [1:0]  MemtoReg,
  output logic [1:0]  RegDst,
  output logic [3:0]  ALUOp,
  output logic        ALUSrc,
  output logic [1:0]  ExtOp,
  output logic        illegal,
  output logic [31:0] retired
);

  localparam logic [3:0] c_ALU_ADD = 4'b0000;
  localparam logic [3:0] c_ALU_SUB = 4'b0001;
  localparam logic [3:0] c_ALU_OR  = 4'b0010;
  localparam logic [3:0] c_ALU_LUI = 4'b0011;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_TRAP = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_retire;
  logic        w_timeout;
  logic        w_unused;

  logic w_is_r, w_addu, w_subu, w_jr, w_ori, w_lui, w_lw, w_sw, w_beq, w_j, w_jal;
  logic w_known;
  logic [1:0] w_dec_jump, w_dec_branch, w_dec_m2r, w_dec_regdst, w_dec_extop;
  logic [3:0] w_dec_aluop;
  logic       w_dec_alusrc;

  // The datapath applies zero to beq itself, so the flag is intentionally unused here.
  assign w_unused = zero;

  always_comb begin
    w_is_r  = (op == 6'h00);
    w_addu  = w_is_r && (funct == 6'h21);
    w_subu  = w_is_r && (funct == 6'h23);
    w_jr    = w_is_r && (funct == 6'h08);
    w_ori   = (op == 6'h0d);
    w_lui   = (op == 6'h0f);
    w_lw    = (op == 6'h23);
    w_sw    = (op == 6'h2b);
    w_beq   = (op == 6'h04);
    w_j     = (op == 6'h02);
    w_jal   = (op == 6'h03);
    w_known = w_addu | w_subu | w_jr | w_ori | w_lui | w_lw | w_sw | w_beq | w_j | w_jal;

    w_dec_jump   = (w_j | w_jal) ? 2'b01 : (w_jr ? 2'b10 : 2'b00);
    w_dec_branch = w_beq ? 2'b01 : 2'b00;
    w_dec_m2r    = w_jal ? 2'b10 : (w_lw ? 2'b01 : 2'b00);
    w_dec_regdst = w_jal ? 2'b10 : (w_is_r ? 2'b01 : 2'b00);
    w_dec_alusrc = w_ori | w_lui | w_lw | w_sw;
    w_dec_extop  = (w_lw | w_sw | w_beq) ? 2'b01 : 2'b00;
    if (w_subu || w_beq)  w_dec_aluop = c_ALU_SUB;
    else if (w_ori)       w_dec_aluop = c_ALU_OR;
    else if (w_lui)       w_dec_aluop = c_ALU_LUI;
    else                  w_dec_aluop = c_ALU_ADD;
  end

  generate
    if (IM_TIMEOUT > 0) begin : g_timeout
      logic [31:0] r_to_cnt;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                r_to_cnt <= '0;
        else if (r_state == S_IF && !imem_ready)   r_to_cnt <= r_to_cnt + 32'd1;
        else                                       r_to_cnt <= '0;
      end
      assign w_timeout = (r_state == S_IF) && !imem_ready &&
                         (r_to_cnt == 32'(IM_TIMEOUT - 1));
    end else begin : g_no_timeout
      assign w_timeout = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IF;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        retired <= '0;
    else if (w_retire) retired <= retired + 32'd1;
  end

  // Everything is forced low while reset is asserted, including fetch requests.
  always_comb begin
    w_next     = r_state;
    w_retire   = 1'b0;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    Jump       = 2'b00;
    Branch_sel = 2'b00;
    MemtoReg   = 2'b00;
    RegDst     = 2'b00;
    ALUOp      = c_ALU_ADD;
    ALUSrc     = 1'b0;
    ExtOp      = 2'b00;
    illegal    = 1'b0;
    if (reset) begin
      if (r_state == S_EX || r_state == S_MEM || r_state == S_WB) begin
        Jump       = w_dec_jump;
        Branch_sel = w_dec_branch;
        MemtoReg   = w_dec_m2r;
        RegDst     = w_dec_regdst;
        ALUOp      = w_dec_aluop;
        ALUSrc     = w_dec_alusrc;
        ExtOp      = w_dec_extop;
      end
      case (r_state)
        S_IF: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            IRWrite = 1'b1;
            w_next  = S_ID;
          end else if (w_timeout) begin
            w_next  = S_TRAP;
          end
        end
        S_ID: w_next = w_known ? S_EX : S_TRAP;
        S_EX: begin
          if (w_beq || w_j || w_jr || w_jal) begin
            PCWrite  = 1'b1;
            RegWrite = w_jal;
            w_retire = 1'b1;
            w_next   = S_IF;
          end else if (w_lw || w_sw) begin
            w_next   = S_MEM;
          end else begin
            w_next   = S_WB;
          end
        end
        S_MEM: begin
          dmem_req = 1'b1;
          if (dmem_ready) begin
            if (w_sw) begin
              MemWrite = 1'b1;
              PCWrite  = 1'b1;
              w_retire = 1'b1;
              w_next   = S_IF;
            end else begin
              w_next   = S_WB;
            end
          end
        end
        S_WB: begin
          RegWrite = 1'b1;
          PCWrite  = 1'b1;
          w_retire = 1'b1;
          w_next   = S_IF;
        end
        S_TRAP:  illegal = 1'b1;
        default: w_next  = S_TRAP;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_multicycle_ctrl : self-checking bench for multicycle_ctrl.            |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_multicycle_ctrl;

  localparam int K_ADDU = 0, K_SUBU = 1, K_ORI = 2, K_LUI = 3, K_LW = 4;
  localparam int K_SW = 5, K_BEQ = 6, K_J = 7, K_JAL = 8, K_JR = 9;

  logic        clk = 1'b0;
  logic        reset, zero, imem_ready, dmem_ready;
  logic [5:0]  op, funct;
  logic        imem_req, dmem_req, IRWrite, PCWrite, RegWrite, MemWrite, ALUSrc, illegal;
  logic [1:0]  Jump, Branch_sel, MemtoReg, RegDst, ExtOp;
  logic [3:0]  ALUOp;
  logic [31:0] retired;

  logic        t_reset, t_imem_ready;
  logic        t_imem_req, t_dmem_req, t_IRWrite, t_PCWrite, t_RegWrite, t_MemWrite;
  logic        t_ALUSrc, t_illegal;
  logic [1:0]  t_Jump, t_Branch_sel, t_MemtoReg, t_RegDst, t_ExtOp;
  logic [3:0]  t_ALUOp;
  logic [31:0] t_retired;

  int n_tests = 0;
  int n_fail  = 0;
  int n_ret   = 0;

  always #5 clk = ~clk;

  multicycle_ctrl u_dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .Jump(Jump), .Branch_sel(Branch_sel),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .ALUOp(ALUOp), .ALUSrc(ALUSrc),
    .ExtOp(ExtOp), .illegal(illegal), .retired(retired)
  );

  multicycle_ctrl #(.IM_TIMEOUT(4)) u_dut_to (
    .clk(clk), .reset(t_reset), .op(op), .funct(funct), .zero(1'b0),
    .imem_ready(t_imem_ready), .dmem_ready(1'b0),
    .imem_req(t_imem_req), .dmem_req(t_dmem_req), .IRWrite(t_IRWrite), .PCWrite(t_PCWrite),
    .RegWrite(t_RegWrite), .MemWrite(t_MemWrite), .Jump(t_Jump), .Branch_sel(t_Branch_sel),
    .MemtoReg(t_MemtoReg), .RegDst(t_RegDst), .ALUOp(t_ALUOp), .ALUSrc(t_ALUSrc),
    .ExtOp(t_ExtOp), .illegal(t_illegal), .retired(t_retired)
  );

  function automatic logic [5:0] op_of(input int k);
    case (k)
      K_ORI: return 6'h0d;  K_LUI: return 6'h0f;  K_LW:  return 6'h23;
      K_SW:  return 6'h2b;  K_BEQ: return 6'h04;  K_J:   return 6'h02;
      K_JAL: return 6'h03;  default: return 6'h00;
    endcase
  endfunction

  function automatic logic [5:0] funct_of(input int k);
    case (k)
      K_ADDU: return 6'h21;  K_SUBU: return 6'h23;  K_JR: return 6'h08;
      default: return 6'($urandom_range(0, 63));
    endcase
  endfunction

  function automatic logic [6:0] strobes();
    return {illegal, imem_req, dmem_req, IRWrite, PCWrite, RegWrite, MemWrite};
  endfunction

  // One instruction with iw fetch wait cycles and dw data wait cycles; expected
  // per-cycle strobes come from the instruction's class latency.
  task automatic run_instr(input int k, input int iw, input int dw);
    int ex_c, last_c, mem_end;
    bit is_lw, is_sw, is_mem, is_jmp, is_wr;
    logic [6:0] exp_v, got_v;
    logic [3:0] exp_alu;
    logic [1:0] exp_jump, exp_m2r, exp_rd;
    is_lw  = (k == K_LW);
    is_sw  = (k == K_SW);
    is_mem = is_lw || is_sw;
    is_jmp = k inside {K_BEQ, K_J, K_JAL, K_JR};
    is_wr  = k inside {K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_JAL};
    ex_c    = iw + 2;
    mem_end = ex_c + 1 + dw;
    if (is_jmp)     last_c = ex_c;
    else if (is_sw) last_c = mem_end;
    else if (is_lw) last_c = mem_end + 1;
    else            last_c = ex_c + 1;
    for (int c = 0; c <= last_c; c++) begin
      @(negedge clk);
      if (c == 0) begin
        op    = op_of(k);
        funct = funct_of(k);
      end
      imem_ready = (c < iw) ? 1'b0 : (c == iw) ? 1'b1 : 1'($urandom_range(0, 1));
      if (is_mem && c > ex_c && c <= mem_end) dmem_ready = (c == mem_end);
      else                                    dmem_ready = 1'($urandom_range(0, 1));
      zero = 1'($urandom_range(0, 1));
      #1;
      exp_v = '0;
      exp_v[5] = (c <= iw);
      exp_v[3] = (c == iw);
      exp_v[4] = is_mem && c > ex_c && c <= mem_end;
      if (c == last_c) begin
        exp_v[2] = 1'b1;
        exp_v[1] = is_wr;
        exp_v[0] = is_sw;
      end
      got_v = strobes();
      n_tests++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL strobes k=%0d cyc=%0d: got %b expected %b (illegal,ireq,dreq,IR,PC,Reg,Mem)",
                 k, c, got_v, exp_v);
      end
      if (c == iw + 1) begin
        n_tests++;
        if ({Jump, Branch_sel, MemtoReg, RegDst, ALUOp, ALUSrc, ExtOp} !== 15'd0) begin
          n_fail++;
          $display("FAIL id_selects k=%0d: got %h expected 0", k,
                   {Jump, Branch_sel, MemtoReg, RegDst, ALUOp, ALUSrc, ExtOp});
        end
      end
      if (c == ex_c && !(k inside {K_J, K_JAL, K_JR})) begin
        case (k)
          K_SUBU, K_BEQ: exp_alu = 4'b0001;
          K_ORI:         exp_alu = 4'b0010;
          K_LUI:         exp_alu = 4'b0011;
          default:       exp_alu = 4'b0000;
        endcase
        n_tests++;
        if (ALUOp !== exp_alu || ALUSrc !== 1'(k inside {K_ORI, K_LUI, K_LW, K_SW})) begin
          n_fail++;
          $display("FAIL ex_alu k=%0d: got ALUOp=%b ALUSrc=%b expected ALUOp=%b", k, ALUOp, ALUSrc, exp_alu);
        end
        if (k inside {K_ORI, K_LW, K_SW, K_BEQ}) begin
          n_tests++;
          if (ExtOp !== ((k == K_ORI) ? 2'b00 : 2'b01)) begin
            n_fail++;
            $display("FAIL ex_extop k=%0d: got %b", k, ExtOp);
          end
        end
      end
      if (c == last_c) begin
        exp_jump = (k == K_J || k == K_JAL) ? 2'b01 : (k == K_JR) ? 2'b10 : 2'b00;
        n_tests++;
        if (Jump !== exp_jump || Branch_sel !== ((k == K_BEQ) ? 2'b01 : 2'b00)) begin
          n_fail++;
          $display("FAIL pc_sel k=%0d: got Jump=%b Branch_sel=%b expected Jump=%b", k, Jump, Branch_sel, exp_jump);
        end
        if (is_wr) begin
          exp_m2r = (k == K_JAL) ? 2'b10 : is_lw ? 2'b01 : 2'b00;
          exp_rd  = (k == K_JAL) ? 2'b10 : (k == K_ADDU || k == K_SUBU) ? 2'b01 : 2'b00;
          n_tests++;
          if (MemtoReg !== exp_m2r || RegDst !== exp_rd) begin
            n_fail++;
            $display("FAIL wb_sel k=%0d: got MemtoReg=%b RegDst=%b expected %b %b",
                     k, MemtoReg, RegDst, exp_m2r, exp_rd);
          end
        end
        n_tests++;
        if (retired !== 32'(n_ret)) begin
          n_fail++;
          $display("FAIL retired k=%0d: got %0d expected %0d", k, retired, n_ret);
        end
      end
    end
    n_ret++;
  endtask

  task automatic test_reset();
    reset = 1'b0;  imem_ready = 1'b1;  dmem_ready = 1'b1;  zero = 1'b0;
    op = 6'h00;  funct = 6'h21;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      n_tests++;
      if (strobes() !== 7'd0 || retired !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_outputs: got strobes=%b retired=%0d expected 0", strobes(), retired);
      end
    end
    @(negedge clk);
    reset = 1'b1;  imem_ready = 1'b0;
    n_ret = 0;
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++)
      run_instr(int'($urandom_range(0, 9)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
  endtask

  task automatic test_trap(input logic [5:0] t_op, input logic [5:0] t_funct, input int n);
    int ret0;
    ret0 = n_ret;
    @(negedge clk);
    op = t_op;  funct = t_funct;  imem_ready = 1'b1;
    #1;
    n_tests++;
    if (IRWrite !== 1'b1) begin
      n_fail++;
      $display("FAIL trap_fetch: got IRWrite=%b expected 1", IRWrite);
    end
    @(negedge clk);
    imem_ready = 1'b1;
    #1;
    n_tests++;
    if (strobes() !== 7'd0) begin
      n_fail++;
      $display("FAIL trap_id: got %b expected 0", strobes());
    end
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      imem_ready = 1'($urandom_range(0, 1));
      dmem_ready = 1'($urandom_range(0, 1));
      #1;
      n_tests++;
      if (strobes() !== 7'b1000000 || retired !== 32'(ret0)) begin
        n_fail++;
        $display("FAIL trap_hold cyc=%0d: got strobes=%b retired=%0d expected 1000000 %0d",
                 c, strobes(), retired, ret0);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_tests++;
    if (illegal !== 1'b0 || retired !== 32'd0) begin
      n_fail++;
      $display("FAIL trap_reset: got illegal=%b retired=%0d expected 0 0", illegal, retired);
    end
    @(negedge clk);
    reset = 1'b1;  imem_ready = 1'b0;
    n_ret = 0;
    run_instr(K_ADDU, 0, 0);
  endtask

  task automatic test_reset_mid_mem();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) begin
        op = 6'h23;  funct = 6'h00;
      end
      imem_ready = (c == 0);
      dmem_ready = 1'b0;
    end
    #1;
    n_tests++;
    if (dmem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_mem_req: got dmem_req=%b expected 1", dmem_req);
    end
    reset = 1'b0;
    #1;
    n_tests++;
    if (strobes() !== 7'd0 || retired !== 32'd0 || MemtoReg !== 2'b00) begin
      n_fail++;
      $display("FAIL mid_mem_async: got strobes=%b retired=%0d expected 0 0", strobes(), retired);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      dmem_ready = 1'b1;  imem_ready = 1'b1;
      #1;
      n_tests++;
      if (strobes() !== 7'd0) begin
        n_fail++;
        $display("FAIL mid_mem_hold: got %b expected 0", strobes());
      end
    end
    @(negedge clk);
    reset = 1'b1;  imem_ready = 1'b0;
    n_ret = 0;
    run_instr(K_ADDU, 0, 0);
    run_instr(K_LW, 0, 0);
  endtask

  task automatic test_timeout();
    logic exp_ill;
    @(negedge clk);
    t_reset = 1'b1;  t_imem_ready = 1'b0;
    op = 6'h00;  funct = 6'h21;
    for (int c = 0; c < 12; c++) begin
      if (c != 0) @(negedge clk);
      t_imem_ready = (c == 3);
      #1;
      exp_ill = (c == 11);
      n_tests++;
      if (t_illegal !== exp_ill || t_IRWrite !== (c == 3)) begin
        n_fail++;
        $display("FAIL timeout cyc=%0d: got illegal=%b IRWrite=%b expected %b %b",
                 c, t_illegal, t_IRWrite, exp_ill, (c == 3));
      end
    end
  endtask

  initial begin
    t_reset = 1'b0;  t_imem_ready = 1'b0;
    test_reset();
    run_instr(K_ADDU, 0, 0);
    run_instr(K_LW, 0, 2);
    run_instr(K_SW, 0, 0);
    run_instr(K_BEQ, 0, 0);
    run_instr(K_JAL, 0, 0);
    run_instr(K_JR, 2, 0);
    test_random(60);
    test_trap(6'h3f, 6'h00, 20);
    test_trap(6'h00, 6'h3f, 5);
    test_reset_mid_mem();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
